core_ins_loader: RTL and testbench
==================================

Name: core_ins_loader

Overview:
- Sequences program loading into the core instruction memory.
- Accepts a 64-bit instruction stream through a valid/ready handshake and packs 64 instructions into one 4096-bit line.
- Drives the memory's one-cycle write strobe with a line index, then advances the index.
- Sits between the host/DMA instruction stream and the instruction memory's write port (web, c_i_m_write_addr, core_ins_input).

Parameters:
- INSTRUCTION_WIDTH, 64, bits per instruction.
- INS_PER_LINE, 64, instructions packed per memory write.
- INS_INTERCORE_DEPTH, 4096, line width; must equal INSTRUCTION_WIDTH*INS_PER_LINE.
- LINE_ADDR_W, 10, valid line-index bits; memory holds 2^LINE_ADDR_W lines.

Ports:
- clk  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; begins a load; ignored unless in IDLE.
- load_base  in  LINE_ADDR_W  first line index; sampled on an accepted load_start.
- load_lines  in  LINE_ADDR_W+1  number of lines; sampled on an accepted load_start.
- s_valid  in  1  stream beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  INSTRUCTION_WIDTH  instruction beat.
- s_last  in  1  final beat of the program.
- web  out  1  memory write strobe.
- c_i_m_write_addr  out  16  line index; upper 16-LINE_ADDR_W bits are always 0.
- core_ins_input  out  INS_INTERCORE_DEPTH  packed line; slot k occupies bits [k*64 +: 64].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- truncated  out  1  sticky flag: the last load ended early because of s_last.

Behaviour:
- Interface decision: one clock clk; reset RSTn is asynchronous, active-low. All state is registered on posedge clk or negedge RSTn.
- Reset values: all outputs 0; state = IDLE; slot index = 0; line buffer = 0; line counter = 0; lines remaining = 0.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - s_ready = 0.
  - On load_start: latch load_base into the line counter and load_lines into lines remaining, clear truncated.
  - If load_lines == 0, go to DONE. Otherwise clear the line buffer and slot index and go to FILL.
- FILL:
  - s_ready = 1.
  - A beat is accepted when s_valid && s_ready. The accepted beat is written to slot[idx] and idx increments.
  - If the beat fills slot 63, or s_last is accepted, go to WRITE.
  - When s_last is accepted and lines remaining > 1, or the line is incomplete, set truncated and set a terminate flag.
  - Unfilled slots stay 0.
- WRITE (exactly one cycle):
  - web = 1; c_i_m_write_addr = line counter; core_ins_input = buffer; s_ready = 0.
  - Line counter increments, wrapping modulo 2^LINE_ADDR_W. Lines remaining decrements.
  - If lines remaining reaches 0 or terminate is set, go to DONE.
  - Otherwise clear the buffer and idx (next cycle observes an all-zero buffer) and go to FILL.
- DONE (one cycle): done = 1, then go to IDLE.
- Timing and data holding:
  - Minimum latency is 64 accepted beats + 1 write cycle per line. Load completion takes ≥ lines*65 + 2 cycles from load_start.
  - core_ins_input and c_i_m_write_addr hold their values outside WRITE. Only web qualifies them.
- Boundary and corner cases:
  - If lines remaining hits 0 while the stream has more beats, the extra beats are not accepted (s_ready = 0 in IDLE).
  - s_last on slot 63 of the final line is a normal completion; truncated = 0.
  - s_last on slot 63 of a non-final line sets truncated.
  - load_start while busy is ignored, with no side effects.
  - Asserting RSTn low mid-load returns everything to reset values immediately. A partial line is never written.
  - s_valid while s_ready = 0 is held off by the source; the beat is not lost.

Decomposition:
- Shared package core_ins_pkg holds:
  - INSTRUCTION_WIDTH, INS_PER_LINE and INS_INTERCORE_DEPTH constants.
  - The loader state enum (IDLE/FILL/WRITE/DONE).
  - A line-index typedef of LINE_ADDR_W bits.
- One natural sub-module, ins_line_packer:
  - Inputs: clear, beat write-enable, 64-bit data.
  - Holds the slot index and the 4096-bit buffer.
  - Outputs: full (slot 63 written) and the buffer.
- The FSM, counters and flags stay in core_ins_loader.

Test Plan:
- Single line:
  - Stimulus: load_start, base=5, lines=1; 64 beats with data=i, s_last on beat 63.
  - Required: exactly one web pulse with addr=5, slot k = k, done one cycle later, truncated=0.
- Multi-line with backpressure:
  - Stimulus: base=0, lines=3; s_valid toggles randomly.
  - Required: web pulses at addr 0, 1, 2 in order; no beat lost or duplicated; s_ready=0 on each WRITE cycle.
- Early s_last:
  - Stimulus: lines=2; s_last on beat 10 of line 0.
  - Required: one write at base with slots 0–10 = data and slots 11–63 = 0; then done; truncated=1.
- Zero lines and busy start:
  - Stimulus: lines=0.
  - Required: done 2 cycles after load_start and no web.
  - Stimulus: load_start pulsed mid-load.
  - Required: it is ignored and the counters are unchanged.
- Wrap-around:
  - Stimulus: base=1023, lines=2.
  - Required: writes at addr 1023 then 0; c_i_m_write_addr[15:10] = 0 throughout.
- Reset mid-fill:
  - Stimulus: RSTn low after beat 30.
  - Required: all outputs 0 asynchronously, no web, state IDLE. A fresh load afterwards works with buffer slots initially 0.

Source files
------------

// File: rtl/core_ins_pkg.sv
// Shared constants and types for the core instruction-memory loader.
package core_ins_pkg;

  localparam int INSTRUCTION_WIDTH   = 64;
  localparam int INS_PER_LINE        = 64;
  localparam int INS_INTERCORE_DEPTH = INSTRUCTION_WIDTH * INS_PER_LINE;
  localparam int LINE_ADDR_W         = 10;
  localparam int SLOT_IDX_W          = $clog2(INS_PER_LINE);
  localparam int MEM_ADDR_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  typedef logic [LINE_ADDR_W-1:0] line_idx_t;
  typedef logic [LINE_ADDR_W:0]   line_cnt_t;
  typedef logic [SLOT_IDX_W-1:0]  slot_idx_t;

  // Memory address bus is wider than the line index; upper bits stay zero.
  function automatic logic [MEM_ADDR_W-1:0] line_to_mem_addr(input line_idx_t line);
    return {{(MEM_ADDR_W-LINE_ADDR_W){1'b0}}, line};
  endfunction

endpackage

// File: rtl/core_ins_loader_if.sv
// Instruction beat stream between the host/DMA source (master) and the loader (slave).
// A beat transfers on a rising clk edge where s_valid && s_ready; the source holds
// s_data/s_last stable while s_valid is high and s_ready is low.
interface core_ins_loader_if;

  logic                                  s_valid;
  logic                                  s_ready;
  logic [core_ins_pkg::INSTRUCTION_WIDTH-1:0] s_data;
  logic                                  s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/ins_line_packer.sv
// Packs accepted instruction beats into one memory line, slot k at bits [k*64 +: 64].
module ins_line_packer
  import core_ins_pkg::*;
(
  input  logic                           clk,
  input  logic                           RSTn,
  input  logic                           clear_i,
  input  logic                           we_i,
  input  logic [INSTRUCTION_WIDTH-1:0]   data_i,
  output logic                           last_slot_o,
  output logic [INS_INTERCORE_DEPTH-1:0] line_o
);

  slot_idx_t                      idx_q;
  logic [INS_INTERCORE_DEPTH-1:0] buf_q;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      idx_q <= '0;
      buf_q <= '0;
    end else if (clear_i) begin
      idx_q <= '0;
      buf_q <= '0;
    end else if (we_i) begin
      buf_q[int'(idx_q)*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] <= data_i;
      idx_q <= idx_q + 1'b1;
    end
  end

  // High while the next written beat lands in slot 63, i.e. completes the line.
  assign last_slot_o = (idx_q == slot_idx_t'(INS_PER_LINE - 1));
  assign line_o      = buf_q;

endmodule

// File: rtl/core_ins_loader.sv
// Program loader: packs a 64-bit beat stream into 4096-bit lines and issues one
// single-cycle write strobe per line at consecutive, wrapping line indices.
module core_ins_loader
  import core_ins_pkg::*;
(
  input  logic                           clk,
  input  logic                           RSTn,
  input  logic                           load_start,
  input  line_idx_t                      load_base,
  input  line_cnt_t                      load_lines,
  core_ins_loader_if.slave               s,
  output logic                           web,
  output logic [MEM_ADDR_W-1:0]          c_i_m_write_addr,
  output logic [INS_INTERCORE_DEPTH-1:0] core_ins_input,
  output logic                           busy,
  output logic                           done,
  output logic                           truncated,
  output loader_state_e                  dbg_state
);

  loader_state_e                  state_q, state_d;
  line_idx_t                      line_cnt_q, line_cnt_d;
  line_cnt_t                      lines_rem_q, lines_rem_d;
  logic                           trunc_q, trunc_d;
  logic                           term_q, term_d;
  line_idx_t                      addr_hold_q;
  logic [INS_INTERCORE_DEPTH-1:0] line_hold_q;

  logic                           pk_clear;
  logic                           pk_we;
  logic                           pk_last_slot;
  logic [INS_INTERCORE_DEPTH-1:0] pk_line;
  logic                           s_ready_c;

  ins_line_packer u_packer (
    .clk         (clk),
    .RSTn        (RSTn),
    .clear_i     (pk_clear),
    .we_i        (pk_we),
    .data_i      (s.s_data),
    .last_slot_o (pk_last_slot),
    .line_o      (pk_line)
  );

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      line_cnt_q  <= '0;
      lines_rem_q <= '0;
      trunc_q     <= 1'b0;
      term_q      <= 1'b0;
      addr_hold_q <= '0;
      line_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      lines_rem_q <= lines_rem_d;
      trunc_q     <= trunc_d;
      term_q      <= term_d;
      // Keep the last written line on the memory bus once the strobe drops.
      if (state_q == ST_WRITE) begin
        addr_hold_q <= line_cnt_q;
        line_hold_q <= pk_line;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    lines_rem_d = lines_rem_q;
    trunc_d     = trunc_q;
    term_d      = term_q;
    pk_clear    = 1'b0;
    pk_we       = 1'b0;
    s_ready_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          line_cnt_d  = load_base;
          lines_rem_d = load_lines;
          trunc_d     = 1'b0;
          term_d      = 1'b0;
          if (load_lines == '0) begin
            state_d = ST_DONE;
          end else begin
            pk_clear = 1'b1;
            state_d  = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        s_ready_c = 1'b1;
        if (s.s_valid) begin
          pk_we = 1'b1;
          if (pk_last_slot || s.s_last) begin
            state_d = ST_WRITE;
          end
          // s_last is only clean when it closes slot 63 of the final line.
          if (s.s_last && ((lines_rem_q > line_cnt_t'(1)) || !pk_last_slot)) begin
            trunc_d = 1'b1;
            term_d  = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        line_cnt_d  = line_cnt_q + 1'b1;
        lines_rem_d = lines_rem_q - 1'b1;
        pk_clear    = 1'b1;
        if ((lines_rem_q == line_cnt_t'(1)) || term_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FILL;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s.s_ready        = s_ready_c;
  assign web              = (state_q == ST_WRITE);
  assign c_i_m_write_addr = web ? line_to_mem_addr(line_cnt_q) : line_to_mem_addr(addr_hold_q);
  assign core_ins_input   = web ? pk_line : line_hold_q;
  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign truncated        = trunc_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_core_ins_loader.sv
// Randomized bench for core_ins_loader: a line-chunking reference model predicts the
// memory writes and truncation flag for each load scenario.
module tb_core_ins_loader;
  import core_ins_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RSTn = 1'b0;
  always #5 clk = ~clk;

  logic                           load_start = 1'b0;
  line_idx_t                      load_base  = '0;
  line_cnt_t                      load_lines = '0;
  logic                           web, busy, done, truncated;
  logic [MEM_ADDR_W-1:0]          c_i_m_write_addr;
  logic [INS_INTERCORE_DEPTH-1:0] core_ins_input;
  loader_state_e                  dbg_state;

  core_ins_loader_if s_if ();

  core_ins_loader dut (
    .clk              (clk),
    .RSTn             (RSTn),
    .load_start       (load_start),
    .load_base        (load_base),
    .load_lines       (load_lines),
    .s                (s_if.slave),
    .web              (web),
    .c_i_m_write_addr (c_i_m_write_addr),
    .core_ins_input   (core_ins_input),
    .busy             (busy),
    .done             (done),
    .truncated        (truncated),
    .dbg_state        (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ---------------- scoreboard ----------------
  logic [63:0]                    beat_data[$];
  logic                           beat_last[$];
  logic [MEM_ADDR_W-1:0]          exp_q[$];
  logic [INS_INTERCORE_DEPTH-1:0] exp_line_q[$];
  logic [MEM_ADDR_W-1:0]          obs_addr_q[$];
  logic [INS_INTERCORE_DEPTH-1:0] obs_line_q[$];
  logic                           exp_trunc;
  int done_cnt = 0;
  int done_cyc = 0;
  int web_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor: records every strobe and checks the bus during it.
  always @(negedge clk) begin
    if (web === 1'b1) begin
      obs_addr_q.push_back(c_i_m_write_addr);
      obs_line_q.push_back(core_ins_input);
      web_cyc = cyc;
      checks++;
      if (s_if.s_ready !== 1'b0 || c_i_m_write_addr[15:LINE_ADDR_W] !== 6'd0) begin
        failures++;
        $display("FAIL write_cycle: s_ready=%b addr=%h, required s_ready=0 and addr[15:10]=0",
                 s_if.s_ready, c_i_m_write_addr);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference model: chop the beat list into 64-slot lines, stopping at s_last or
  // after the requested number of lines.
  function automatic void build_expect(input int base, input int lines);
    int slot = 0;
    int line = 0;
    logic [INS_INTERCORE_DEPTH-1:0] cur = '0;
    exp_trunc = 1'b0;
    exp_q.delete();
    exp_line_q.delete();
    for (int b = 0; b < beat_data.size() && line < lines; b++) begin
      cur[slot*64 +: 64] = beat_data[b];
      slot++;
      if (slot == 64 || beat_last[b]) begin
        exp_q.push_back(16'((base + line) % 1024));
        exp_line_q.push_back(cur);
        if (beat_last[b] && (slot < 64 || line < lines - 1)) begin
          exp_trunc = 1'b1;
          break;
        end
        line++;
        slot = 0;
        cur  = '0;
      end
    end
  endfunction

  function automatic int first_diff_slot(input logic [INS_INTERCORE_DEPTH-1:0] a,
                                         input logic [INS_INTERCORE_DEPTH-1:0] b);
    for (int k = 0; k < 64; k++) if (a[k*64 +: 64] !== b[k*64 +: 64]) return k;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic gen_beats(input int n, input int last_at);
    beat_data.delete();
    beat_last.delete();
    for (int i = 0; i < n; i++) begin
      beat_data.push_back({$urandom, $urandom});
      beat_last.push_back(i == last_at);
    end
  endtask

  task automatic start_load(input int base, input int lines);
    @(posedge clk); #1;
    load_start = 1'b1;
    load_base  = line_idx_t'(base);
    load_lines = line_cnt_t'(lines);
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_beats(input int from, input int upto, input bit bp, output int sent);
    int  i = from;
    int  guard = 0;
    bit  acc;
    while (i < upto && guard < 3000) begin
      s_if.s_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_if.s_data  = beat_data[i];
      s_if.s_last  = beat_last[i];
      @(negedge clk);
      acc = s_if.s_valid && s_if.s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
    sent = i - from;
  endtask

  task automatic wait_done(input int start_cnt, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (done_cnt > start_cnt) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RSTn = 1'b0;
    #12;
    checks++;
    if ({web, busy, done, truncated} !== 4'b0 || c_i_m_write_addr !== 16'h0 ||
        core_ins_input !== '0 || s_if.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: web=%b busy=%b done=%b trunc=%b addr=%h line_or=%b s_ready=%b, required all 0",
               web, busy, done, truncated, c_i_m_write_addr, |core_ins_input, s_if.s_ready);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: state=%0d, required %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    RSTn = 1'b1;
  endtask

  task automatic test_single_line();
    int sent; bit ok; int d0;
    beat_data.delete(); beat_last.delete();
    for (int i = 0; i < 64; i++) begin
      beat_data.push_back(64'(i));
      beat_last.push_back(i == 63);
    end
    build_expect(5, 1);
    obs_addr_q.delete(); obs_line_q.delete();
    d0 = done_cnt;
    start_load(5, 1);
    send_beats(0, 64, 1'b0, sent);
    wait_done(d0, ok);
    checks++;
    if (sent != 64 || !ok) begin
      failures++;
      $display("FAIL single_progress: beats=%0d done=%b, required 64 and 1", sent, ok);
    end
    checks++;
    if (obs_addr_q.size() != 1 || obs_addr_q[0] !== 16'd5 || obs_line_q[0] !== exp_line_q[0]) begin
      failures++;
      $display("FAIL single_write: writes=%0d addr=%h, required 1 write at 0005 with slot k = k",
               obs_addr_q.size(), (obs_addr_q.size() > 0) ? obs_addr_q[0] : 16'hffff);
    end
    checks++;
    if (done_cyc != web_cyc + 1 || truncated !== 1'b0) begin
      failures++;
      $display("FAIL single_done: done_cyc=%0d web_cyc=%0d trunc=%b, required done_cyc=web_cyc+1 trunc=0",
               done_cyc, web_cyc, truncated);
    end
  endtask

  task automatic test_multi_backpressure();
    int sent; bit ok; int d0;
    gen_beats(192, 191);
    build_expect(0, 3);
    obs_addr_q.delete(); obs_line_q.delete();
    d0 = done_cnt;
    start_load(0, 3);
    send_beats(0, 192, 1'b1, sent);
    wait_done(d0, ok);
    checks++;
    if (sent != 192 || !ok || obs_addr_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL multi_progress: beats=%0d done=%b writes=%0d, required 192, 1, %0d",
               sent, ok, obs_addr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_addr_q[i] !== exp_q[i] || obs_line_q[i] !== exp_line_q[i]) begin
          failures++;
          $display("FAIL multi_write%0d: addr=%h slot%0d=%h, required addr=%h slot=%h", i, obs_addr_q[i],
                   first_diff_slot(obs_line_q[i], exp_line_q[i]),
                   obs_line_q[i][first_diff_slot(obs_line_q[i], exp_line_q[i])*64 +: 64], exp_q[i],
                   exp_line_q[i][first_diff_slot(obs_line_q[i], exp_line_q[i])*64 +: 64]);
        end
      end
    end
    checks++;
    if (truncated !== exp_trunc) begin
      failures++;
      $display("FAIL multi_trunc: trunc=%b, required %b", truncated, exp_trunc);
    end
  endtask

  task automatic test_early_last();
    int sent; bit ok; int d0; int base;
    base = $urandom_range(0, 1023);
    gen_beats(11, 10);
    build_expect(base, 2);
    obs_addr_q.delete(); obs_line_q.delete();
    d0 = done_cnt;
    start_load(base, 2);
    send_beats(0, 11, 1'b1, sent);
    wait_done(d0, ok);
    checks++;
    if (!ok || obs_addr_q.size() != 1 || obs_addr_q[0] !== exp_q[0] || obs_line_q[0] !== exp_line_q[0]) begin
      failures++;
      $display("FAIL early_write: done=%b writes=%0d addr=%h, required 1 write at %h with slots 11-63 zero",
               ok, obs_addr_q.size(), (obs_addr_q.size() > 0) ? obs_addr_q[0] : 16'hffff, exp_q[0]);
    end
    checks++;
    if (truncated !== exp_trunc) begin
      failures++;
      $display("FAIL early_trunc: trunc=%b, required %b", truncated, exp_trunc);
    end
  endtask

  task automatic test_zero_and_busy_start();
    int sent; bit ok; int d0; int w0;
    // Zero-line load: DONE in the cycle after the accepted start, no strobe.
    w0 = obs_addr_q.size();
    @(posedge clk); #1;
    load_start = 1'b1; load_base = 10'd77; load_lines = '0;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_done: done=%b busy=%b, required 1 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || obs_addr_q.size() != w0) begin
      failures++;
      $display("FAIL zero_after: done=%b busy=%b new_writes=%0d, required 0 0 0",
               done, busy, obs_addr_q.size() - w0);
    end
    // Start pulse while filling must be ignored.
    gen_beats(128, 127);
    build_expect(100, 2);
    obs_addr_q.delete(); obs_line_q.delete();
    d0 = done_cnt;
    start_load(100, 2);
    send_beats(0, 20, 1'b1, sent);
    load_start = 1'b1; load_base = 10'd7; load_lines = 11'd1;
    @(posedge clk); #1;
    load_start = 1'b0;
    checks++;
    if (dbg_state !== ST_FILL) begin
      failures++;
      $display("FAIL busy_start_state: state=%0d, required %0d", dbg_state, ST_FILL);
    end
    send_beats(20, 128, 1'b1, sent);
    wait_done(d0, ok);
    checks++;
    if (!ok || obs_addr_q.size() != 2 || obs_addr_q[0] !== exp_q[0] || obs_addr_q[1] !== exp_q[1] ||
        obs_line_q[0] !== exp_line_q[0] || obs_line_q[1] !== exp_line_q[1] || truncated !== exp_trunc) begin
      failures++;
      $display("FAIL busy_start_writes: done=%b writes=%0d trunc=%b, required 2 writes at 0064,0065 trunc=%b",
               ok, obs_addr_q.size(), truncated, exp_trunc);
    end
  endtask

  task automatic test_wrap_and_overflow();
    int sent; bit ok; int d0; int w0;
    gen_beats(128, -1);
    build_expect(1023, 2);
    obs_addr_q.delete(); obs_line_q.delete();
    d0 = done_cnt;
    start_load(1023, 2);
    send_beats(0, 128, 1'b1, sent);
    wait_done(d0, ok);
    checks++;
    if (!ok || obs_addr_q.size() != 2 || obs_addr_q[0] !== 16'd1023 || obs_addr_q[1] !== 16'd0 ||
        obs_line_q[0] !== exp_line_q[0] || obs_line_q[1] !== exp_line_q[1]) begin
      failures++;
      $display("FAIL wrap_writes: done=%b writes=%0d, required writes at 03ff then 0000", ok, obs_addr_q.size());
    end
    checks++;
    if (truncated !== exp_trunc) begin
      failures++;
      $display("FAIL wrap_trunc: trunc=%b, required %b", truncated, exp_trunc);
    end
    // Extra beats after the load has finished are never accepted.
    w0 = obs_addr_q.size();
    s_if.s_valid = 1'b1;
    s_if.s_data  = {$urandom, $urandom};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (s_if.s_ready !== 1'b0) begin
        failures++;
        $display("FAIL overflow_ready: s_ready=%b, required 0", s_if.s_ready);
      end
    end
    s_if.s_valid = 1'b0;
    checks++;
    if (obs_addr_q.size() != w0) begin
      failures++;
      $display("FAIL overflow_write: new_writes=%0d, required 0", obs_addr_q.size() - w0);
    end
  endtask

  task automatic test_reset_mid_fill();
    int sent; bit ok; int d0; int w0;
    gen_beats(64, 63);
    w0 = obs_addr_q.size();
    start_load(42, 1);
    send_beats(0, 31, 1'b0, sent);
    #2;
    RSTn = 1'b0;
    #1;
    checks++;
    if ({web, busy, done, truncated} !== 4'b0 || c_i_m_write_addr !== 16'h0 ||
        core_ins_input !== '0 || s_if.s_ready !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL midreset_outputs: web=%b busy=%b done=%b trunc=%b addr=%h line_or=%b state=%0d, required all 0/IDLE",
               web, busy, done, truncated, c_i_m_write_addr, |core_ins_input, dbg_state);
    end
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    checks++;
    if (obs_addr_q.size() != w0 || sent != 31) begin
      failures++;
      $display("FAIL midreset_nowrite: new_writes=%0d beats=%0d, required 0 and 31", obs_addr_q.size() - w0, sent);
    end
    // A fresh short load must see a cleared line buffer.
    gen_beats(5, 4);
    build_expect(9, 1);
    obs_addr_q.delete(); obs_line_q.delete();
    d0 = done_cnt;
    start_load(9, 1);
    send_beats(0, 5, 1'b0, sent);
    wait_done(d0, ok);
    checks++;
    if (!ok || obs_addr_q.size() != 1 || obs_addr_q[0] !== exp_q[0] || obs_line_q[0] !== exp_line_q[0] ||
        truncated !== exp_trunc) begin
      failures++;
      $display("FAIL midreset_reload: done=%b writes=%0d trunc=%b, required 1 write at 0009 slots 5-63 zero trunc=%b",
               ok, obs_addr_q.size(), truncated, exp_trunc);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;
    test_reset();
    test_single_line();
    test_multi_backpressure();
    test_early_last();
    test_zero_and_busy_start();
    test_wrap_and_overflow();
    test_reset_mid_fill();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
